// File: rtl/bit_count_sched_if.sv
// Request/response bundle between requesters, the consumer and bit_count_sched.
// Every transfer is valid/ready: it happens on a rising edge where both are high; once raised, valid and its payload hold until that edge.
interface bit_count_sched_if #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [CW-1:0]            resp_data;
  logic [IW-1:0]            resp_id;
  logic                     resp_err;

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_err
  );

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_err
  );
endinterface

// File: rtl/bit_count_sched.sv
// Round-robin arbiter and sequencer for a shared clear-lowest-bit population-count datapath.
// One operation in flight; results are returned tagged with the owning requester.
module bit_count_sched #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  bit_count_sched_if.slave             bus,
  output logic                         busy,
  output logic [WIDTH-1:0]             dp_in,
  output logic                         dp_n_en,
  output logic                         dp_n_sel,
  output logic                         dp_count_en,
  output logic                         dp_count_sel,
  output logic                         dp_out_en,
  input  logic                         dp_n_eq_0,
  input  logic [$clog2(WIDTH+1)-1:0]   dp_out,
  output logic [1:0]                   dbg_state
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   iter;
  logic [IW-1:0]   resp_id_q;
  logic            resp_err_q;

  logic [WIDTH-1:0] req_op [NUM_REQ];
  logic [IW-1:0]    grant, cand;
  logic             found;
  logic             accept, loop_step, set_err, resp_fire, resp_valid_c;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_op[i] = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  // Search starts just above the last grant so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    state_next    = state;
    bus.req_ready = '0;
    dp_in         = '0;
    dp_n_en       = 1'b0;
    dp_n_sel      = 1'b0;
    dp_count_en   = 1'b0;
    dp_count_sel  = 1'b0;
    dp_out_en     = 1'b0;
    accept        = 1'b0;
    loop_step     = 1'b0;
    set_err       = 1'b0;
    resp_fire     = 1'b0;
    resp_valid_c  = 1'b0;
    unique case (state)
      IDLE: begin
        // Gating on rst keeps req_ready and the strobes quiet while reset is held.
        if (rst && found) begin
          bus.req_ready[grant] = 1'b1;
          dp_in        = req_op[grant];
          dp_n_en      = 1'b1;
          dp_n_sel     = 1'b1;
          dp_count_en  = 1'b1;
          dp_count_sel = 1'b1;
          accept       = 1'b1;
          state_next   = LOOP;
        end
      end
      LOOP: begin
        if (dp_n_eq_0) begin
          dp_out_en  = 1'b1;
          state_next = DONE;
        end else if (iter == CW'(WIDTH)) begin
          dp_out_en  = 1'b1;
          set_err    = 1'b1;
          state_next = DONE;
        end else begin
          dp_n_en     = 1'b1;
          dp_count_en = 1'b1;
          loop_step   = 1'b1;
        end
      end
      DONE: begin
        resp_valid_c = 1'b1;
        if (bus.resp_ready) begin
          resp_fire  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_ptr     <= IW'(NUM_REQ - 1);
      iter       <= '0;
      resp_id_q  <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        resp_id_q <= grant;
        rr_ptr    <= grant;
        iter      <= '0;
      end else if (loop_step) begin
        iter <= iter + 1'b1;
      end
      if (set_err) begin
        resp_err_q <= 1'b1;
      end else if (resp_fire) begin
        resp_err_q <= 1'b0;
      end
    end
  end

  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_data  = resp_valid_c ? dp_out : '0;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_err   = resp_err_q;
  assign busy           = (state != IDLE);
  assign dbg_state      = state;
endmodule

// File: tb/tb_bit_count_sched.sv
// Bench for bit_count_sched with a behavioural datapath and a transaction-level reference model.
module tb_bit_count_sched;
  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int CW      = $clog2(WIDTH + 1);
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int W       = 1 + IW + CW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic stuck = 1'b0;
  int   cyc   = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT and datapath ----------------
  bit_count_sched_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  logic             busy, dp_n_en, dp_n_sel, dp_count_en, dp_count_sel, dp_out_en, dp_n_eq_0;
  logic [WIDTH-1:0] dp_in, dp_n;
  logic [CW-1:0]    dp_cnt, dp_out;
  logic [1:0]       dbg_state;
  logic [WIDTH-1:0] op [NUM_REQ];

  bit_count_sched #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .busy         (busy),
    .dp_in        (dp_in),
    .dp_n_en      (dp_n_en),
    .dp_n_sel     (dp_n_sel),
    .dp_count_en  (dp_count_en),
    .dp_count_sel (dp_count_sel),
    .dp_out_en    (dp_out_en),
    .dp_n_eq_0    (dp_n_eq_0),
    .dp_out       (dp_out),
    .dbg_state    (dbg_state)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_n   <= '0;
      dp_cnt <= '0;
      dp_out <= '0;
    end else begin
      if (dp_n_en) dp_n <= dp_n_sel ? dp_in : (dp_n & (dp_n - 1'b1));
      if (dp_count_en) dp_cnt <= dp_count_sel ? '0 : dp_cnt + 1'b1;
      if (dp_out_en) dp_out <= dp_cnt;
    end
  end
  assign dp_n_eq_0 = stuck ? 1'b0 : (dp_n == '0);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = op[i];
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a free/busy flag, the last winner, and the cycle the answer is due.
  bit m_busy = 1'b0;
  int m_ptr  = NUM_REQ - 1;
  int m_due  = 0;

  always @(negedge clk) begin
    logic [NUM_REQ-1:0] exp_ready;
    logic               exp_rv;
    int                 g;
    int                 k;
    exp_ready = '0;
    exp_rv    = 1'b0;
    g         = -1;
    k         = 0;
    if (!rst) begin
      check("reset_outputs",
            {bus.req_ready, bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_err, busy,
             dp_in, dp_n_en, dp_n_sel, dp_count_en, dp_count_sel, dp_out_en}, '0);
      m_busy = 1'b0;
      m_ptr  = NUM_REQ - 1;
      exp_q.delete();
    end else begin
      check("busy", busy, m_busy);
      if (!m_busy) begin
        for (int i = 1; i <= NUM_REQ; i++) begin
          if (g < 0 && bus.req_valid[(m_ptr + i) % NUM_REQ]) g = (m_ptr + i) % NUM_REQ;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", bus.req_ready, exp_ready);
      check("req_ready_onehot0", $onehot0(bus.req_ready), 1);
      exp_rv = m_busy && (cyc >= m_due);
      check("resp_valid", bus.resp_valid, exp_rv);
      if (exp_rv && bus.resp_valid) begin
        if (exp_q.size() > 0) check("resp_payload", {bus.resp_err, bus.resp_id, bus.resp_data}, exp_q[0]);
        else check("resp_q_size", exp_q.size(), 1);
      end
      if (g >= 0) begin
        k = stuck ? WIDTH : $countones(op[g]);
        exp_q.push_back({stuck, IW'(g), CW'(k)});
        m_due  = cyc + k + 2;
        m_busy = 1'b1;
        m_ptr  = g;
      end else if (exp_rv && bus.resp_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_busy = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (!busy && !bus.resp_valid) got = 1'b1;
    end
    check("idle_timeout", got, 1);
    step();
  endtask

  task automatic run_one(input int idx, input logic [WIDTH-1:0] d, input int exp_d,
                         input int exp_lat, input logic exp_err);
    bit got;
    int t0;
    got = 1'b0;
    t0  = 0;
    op[idx]        = d;
    bus.req_valid  = '0;
    bus.req_valid[idx] = 1'b1;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready[idx]) begin
        got = 1'b1;
        t0  = cyc;
      end
    end
    check("accept_timeout", got, 1);
    step();
    bus.req_valid = '0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        got = 1'b1;
        check("latency", cyc - t0, exp_lat);
        check("lit_resp_data", bus.resp_data, exp_d);
        check("lit_resp_id", bus.resp_id, idx);
        check("lit_resp_err", bus.resp_err, exp_err);
      end
    end
    check("resp_timeout", got, 1);
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int order [5];
    int exp_order [5];
    int n;
    bit got;
    exp_order = '{0, 1, 2, 3, 0};
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) op[i] = '0;

    reset_dut();

    // Single operands and latency corners.
    run_one(0, 8'hB5, 5, 7, 1'b0);
    run_one(0, 8'h00, 0, 2, 1'b0);
    run_one(0, 8'hFF, 8, 10, 1'b0);
    run_one(0, 8'h80, 1, 3, 1'b0);

    // Round-robin with every requester pending.
    reset_dut();
    op[0] = 8'h01; op[1] = 8'h03; op[2] = 8'h07; op[3] = 8'h0F;
    bus.req_valid  = '1;
    bus.resp_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 120 && n < 5; i++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        for (int j = 0; j < NUM_REQ; j++) if (bus.req_ready[j]) order[n] = j;
        n++;
      end
    end
    check("grant_count", n, 5);
    for (int i = 0; i < 5; i++) check("grant_order", order[i], exp_order[i]);

    // Back-pressure in DONE on the fifth transaction (requester 0, one set bit).
    step();
    bus.resp_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.resp_valid) got = 1'b1;
    end
    check("stall_resp_timeout", got, 1);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", bus.resp_valid, 1);
      check("stall_data", bus.resp_data, 1);
      check("stall_id", bus.resp_id, 0);
      check("stall_req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    step();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("handshake_req_ready", bus.req_ready, 0);
    @(negedge clk);
    check("next_grant", bus.req_ready, 4'b0010);
    step();
    wait_idle();

    // Reset in the middle of LOOP, then priority restarts at requester 0.
    op[0] = 8'hFF;
    bus.req_valid  = 4'b0001;
    bus.resp_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready[0]) got = 1'b1;
    end
    check("rst_accept_timeout", got, 1);
    step();
    bus.req_valid = '0;
    step();
    step();
    op[0] = 8'h0F;
    op[2] = 8'h33;
    bus.req_valid = 4'b0101;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_req_ready", bus.req_ready, 0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_grant", bus.req_ready, 4'b0001);
    step();
    wait_idle();

    // Stuck n != 0 trips the iteration bound.
    stuck = 1'b1;
    run_one(2, 8'h03, 8, 10, 1'b1);
    stuck = 1'b0;
    wait_idle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.req_valid  = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      for (int j = 0; j < NUM_REQ; j++) op[j] = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
